spike_rate_decoder: RTL

//  Receive end of the LIF spike interface: turns a 1-bit spike train back into an 8-bit

---
 rtl/spike_dec_pkg.sv | 15 +
 rtl/spike_edge_det.sv | 32 +++
 rtl/spike_rate_decoder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/spike_dec_pkg.sv
// spike_dec_pkg: shared types and constants for the spike rate decoder.
//   RATE_W    width of the reported rate value
//   SAT_MAX   saturated rate value
//   out_state_t  output holding FSM states
//   sat_inc8  saturating 8-bit increment (used by the optional ISI block)
package spike_dec_pkg;
  localparam int RATE_W = 8;
  localparam logic [RATE_W-1:0] SAT_MAX = 8'hFF;

  typedef enum logic {S_EMPTY, S_FULL} out_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/spike_edge_det.sv
// spike_edge_det: rising-edge event detector for the incoming spike level.
//   i_clk, i_rst_n  clock, synchronous active-low reset
//   i_ena           enable; low holds the previous-level register
//   i_spike         spike level from the neuron
//   o_evt           one-cycle event on an enabled 0->1 transition
module spike_edge_det
  import spike_dec_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ena,
  input  logic i_spike,
  output logic o_evt
);
  logic r_prev;
  // r_armed is clear until the first enabled cycle after reset has sampled
  // the line, so a spike level already high when reset lifts is not taken
  // as an edge.
  logic r_armed;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
    end else if (i_ena) begin
      r_prev  <= i_spike;
      r_armed <= 1'b1;
    end
  end

  assign o_evt = i_ena & r_armed & i_spike & ~r_prev;
endmodule

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: counts spike events over a window of WIN_LEN enabled
// cycles and presents each window's count on a valid/ready port.
//   clk, rst_n   clock, synchronous active-low reset
//   ena          enable; low freezes window and spike counting
//   spike_in     spike level, event = 0->1 transition
//   rate_out     count of last closed window, saturated at 8'hFF
//   rate_valid   rate_out holds an unconsumed result
//   rate_ready   consumer accept
//   sat          rate_out saturated, qualified by rate_valid
//   overrun      sticky: window closed while previous result unconsumed
//   isi_out      inter-spike interval in enabled cycles
// Optional feature macro: SPIKE_ISI_EN (inter-spike interval output).
module spike_rate_decoder
  import spike_dec_pkg::*;
#(
  parameter int unsigned WIN_LEN = 16'd255,
  parameter int unsigned WIN_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              spike_in,
  output logic [RATE_W-1:0] rate_out,
  output logic              rate_valid,
  input  logic              rate_ready,
  output logic              sat,
  output logic              overrun,
  output logic [7:0]        isi_out
);
  localparam logic [WIN_W-1:0] LAST = WIN_W'(WIN_LEN - 1);

  logic             w_evt;
  logic             w_close;
  logic [9:0]       w_total;
  logic [WIN_W-1:0] r_win_cnt;
  logic [8:0]       r_spk_cnt;
  out_state_t       r_state;
  logic [RATE_W-1:0] r_rate;
  logic             r_valid;
  logic             r_sat;
  logic             r_overrun;

  spike_edge_det u_edge (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_ena   (ena),
    .i_spike (spike_in),
    .o_evt   (w_evt)
  );

  assign w_close = ena && (r_win_cnt == LAST);
  // An event on the close cycle belongs to the closing window.
  assign w_total = {1'b0, r_spk_cnt} + {9'd0, w_evt};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_win_cnt <= '0;
      r_spk_cnt <= '0;
    end else if (ena) begin
      if (w_close) begin
        r_win_cnt <= '0;
        r_spk_cnt <= '0;
      end else begin
        r_win_cnt <= r_win_cnt + 1'b1;
        // Saturate at 256; anything >= 255 reports as SAT_MAX anyway.
        if (w_evt && r_spk_cnt != 9'h100)
          r_spk_cnt <= r_spk_cnt + 9'd1;
      end
    end
  end

  // Output holding FSM; a close always loads the new window result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_EMPTY;
      r_rate    <= '0;
      r_valid   <= 1'b0;
      r_sat     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_close) begin
        r_rate  <= (w_total >= 10'd255) ? SAT_MAX : w_total[RATE_W-1:0];
        r_sat   <= (w_total >= 10'd255);
        r_state <= S_FULL;
        r_valid <= 1'b1;
        if (r_state == S_FULL && !rate_ready)
          r_overrun <= 1'b1;
      end else if (r_state == S_FULL && rate_ready) begin
        r_state <= S_EMPTY;
        r_valid <= 1'b0;
      end
    end
  end

  assign rate_out   = r_rate;
  assign rate_valid = r_valid;
  assign sat        = r_sat & r_valid;
  assign overrun    = r_overrun;

`ifdef SPIKE_ISI_EN
  logic [7:0] r_isi_cnt;
  logic [7:0] r_isi;

  // r_isi_cnt holds enabled cycles since the last event, so the interval
  // between two events is that count plus the event cycle itself.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_isi_cnt <= 8'd0;
      r_isi     <= 8'd0;
    end else if (ena) begin
      if (w_evt) begin
        r_isi     <= sat_inc8(r_isi_cnt);
        r_isi_cnt <= 8'd0;
      end else begin
        r_isi_cnt <= sat_inc8(r_isi_cnt);
      end
    end
  end

  assign isi_out = r_isi;
`else
  assign isi_out = 8'd0;
`endif
endmodule
